voice_control_regs: RTL and testbench
=====================================

VOICE_CONTROL_REGS -- requirements
Module: voice_control_regs

Interface
REQ-001 Parameter RETRIG_CYCLES, default 4: number of cycles gate is held low during a retrigger; legal range 1..255.
REQ-002 Port clk  input  1: single clock; all state is updated on the rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-low.
REQ-004 Port wr_valid  input  1: write request from the bus initiator.
REQ-005 Port wr_ready  output  1: the block can accept a write this cycle.
REQ-006 Port wr_addr  input  3: register address.
REQ-007 Port wr_data  input  8: write data.
REQ-008 Port bad_addr  output  1: one-cycle pulse when an accepted write targets address 7.
REQ-009 Port tone_freq  output  16: committed oscillator frequency word.
REQ-010 Port pulse_width  output  12: committed pulse width.
REQ-011 Port waveform_enable  output  4: bit3 noise, bit2 pulse, bit1 saw, bit0 triangle.
REQ-012 Port gate, en_sync, en_ringmod  output  1 each: voice controls.
REQ-013 Port attack, decay, sustain, rel  output  4 each: envelope parameters.

Function
REQ-014 A write is accepted on a rising edge where wr_valid=1 and wr_ready=1. Its effect is visible on the outputs in the following cycle, with single-cycle latency.
REQ-015 Address map:
- 0: freq_lo shadow
- 1: freq_hi
- 2: pw_lo shadow
- 3: pw_hi (wr_data[3:0] used, [7:4] ignored)
- 4: control
- 5: attack=[7:4], decay=[3:0]
- 6: sustain=[7:4], rel=[3:0]
REQ-016 A write to address 0 or 2 updates only the 8-bit shadow; tone_freq and pulse_width are unchanged.
REQ-017 A write to address 1 sets tone_freq to {wr_data, freq_lo shadow} atomically. Only the high byte commits.
REQ-018 A write to address 3 sets pulse_width to {wr_data[3:0], pw_lo shadow} atomically.
REQ-019 Control byte layout:
- [7:4] waveform_enable
- [3] retrig
- [2] en_ringmod
- [1] en_sync
- [0] gate request
REQ-020 Writes to addresses 5 and 6 update their envelope outputs directly, with no shadowing.
REQ-021 A write to address 7 changes no register and pulses bad_addr high for exactly the next cycle. wr_ready is unaffected.
REQ-022 FSM has two states: IDLE and RETRIG. In IDLE, wr_ready=1. In RETRIG, wr_ready=0 and writes are not accepted.
REQ-023 Control write in IDLE with gate request=1, retrig=1, and current gate=1:
- gate goes 0 next cycle;
- an 8-bit counter loads RETRIG_CYCLES-1;
- FSM enters RETRIG.
All other control fields update normally.
REQ-024 In RETRIG, the counter decrements each cycle. When the counter is 0:
- gate returns to 1 next cycle;
- FSM returns to IDLE.
gate is therefore low for exactly RETRIG_CYCLES cycles.
REQ-025 In all other cases, a control write copies gate request into gate directly and stays in IDLE. This includes retrig=1 with current gate=0, and retrig=1 with gate request=0.
REQ-026 The shadow registers are not cleared by a commit. A second hi write without a new lo write reuses the previous lo byte.

Reset
REQ-027 While rst=0, all outputs and internal state are forced to zero immediately, independent of clk: tone_freq, pulse_width, waveform_enable, gate, en_sync, en_ringmod, attack, decay, sustain, rel, shadows, counter, and bad_addr.
REQ-028 During and after reset, FSM=IDLE and wr_ready=1. Reset asserted mid-RETRIG aborts the retrigger, and gate stays 0 after release.
REQ-029 The first edge after rst deasserts may accept a write.

Verification
REQ-030 Write addr0=0x34, then addr1=0x12 -> tone_freq stays 0x0000 after the first write and reads 0x1234 one cycle after the second.
REQ-031 Write addr2=0xFF, then addr3=0xA7 -> pulse_width=0x7FF. Then write addr3=0x01 alone -> pulse_width=0x1FF.
REQ-032 Write addr4=0x41, then addr4=0x49 with RETRIG_CYCLES=4 -> gate=1, then 0 for exactly 4 cycles, then 1. wr_ready=0 for those same 4 cycles. A wr_valid held during RETRIG is accepted only after wr_ready returns to 1.
REQ-033 Write addr5=0x9C, addr6=0x53, and addr7=0xFF -> attack=9, decay=C, sustain=5, rel=3. bad_addr pulses once. No other output changes.
REQ-034 Assert rst=0 during the second RETRIG cycle -> all outputs 0 and wr_ready=1 immediately. After release, gate remains 0 until the next control write.

Source files
------------

// File: rtl/voice_control_regs.sv
// Register block for one synthesizer voice: byte-wide write port, shadowed
// 16/12-bit commits and a gate retrigger sequencer that stalls the bus.
module voice_control_regs #(
    parameter int RETRIG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        bad_addr,
    output logic [15:0] tone_freq,
    output logic [11:0] pulse_width,
    output logic [3:0]  waveform_enable,
    output logic        gate,
    output logic        en_sync,
    output logic        en_ringmod,
    output logic [3:0]  attack,
    output logic [3:0]  decay,
    output logic [3:0]  sustain,
    output logic [3:0]  rel
);

    typedef enum logic {
        IDLE   = 1'b0,
        RETRIG = 1'b1
    } state_t;

    localparam logic [7:0] RETRIG_LOAD = 8'(RETRIG_CYCLES - 1);

    localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
    localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
    localparam logic [2:0] ADDR_PW_LO   = 3'd2;
    localparam logic [2:0] ADDR_PW_HI   = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;
    localparam logic [2:0] ADDR_AD      = 3'd5;
    localparam logic [2:0] ADDR_SR      = 3'd6;
    localparam logic [2:0] ADDR_BAD     = 3'd7;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       gate_nxt;
    logic [7:0] freq_lo_shadow;
    logic [7:0] pw_lo_shadow;
    logic       wr_en;
    logic       ctrl_wr;
    logic       start_retrig;

    assign wr_ready = (state == IDLE);
    assign wr_en    = wr_valid && wr_ready;
    assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);

    // Retrigger only when the voice is already sounding and both request bits are set.
    assign start_retrig = ctrl_wr && wr_data[0] && wr_data[3] && gate;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            gate  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gate  <= gate_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gate_nxt  = gate;
        case (state)
            IDLE: begin
                if (start_retrig) begin
                    gate_nxt  = 1'b0;
                    cnt_nxt   = RETRIG_LOAD;
                    state_nxt = RETRIG;
                end else if (ctrl_wr) begin
                    gate_nxt = wr_data[0];
                end
            end
            RETRIG: begin
                if (cnt == 8'd0) begin
                    gate_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_addr        <= 1'b0;
            freq_lo_shadow  <= 8'd0;
            pw_lo_shadow    <= 8'd0;
            tone_freq       <= 16'd0;
            pulse_width     <= 12'd0;
            waveform_enable <= 4'd0;
            en_sync         <= 1'b0;
            en_ringmod      <= 1'b0;
            attack          <= 4'd0;
            decay           <= 4'd0;
            sustain         <= 4'd0;
            rel             <= 4'd0;
        end else begin
            bad_addr <= wr_en && (wr_addr == ADDR_BAD);
            if (wr_en) begin
                // Shadows are kept after a commit so a lone hi write reuses the old lo byte.
                case (wr_addr)
                    ADDR_FREQ_LO: freq_lo_shadow <= wr_data;
                    ADDR_FREQ_HI: tone_freq      <= {wr_data, freq_lo_shadow};
                    ADDR_PW_LO:   pw_lo_shadow   <= wr_data;
                    ADDR_PW_HI:   pulse_width    <= {wr_data[3:0], pw_lo_shadow};
                    ADDR_CTRL: begin
                        waveform_enable <= wr_data[7:4];
                        en_ringmod      <= wr_data[2];
                        en_sync         <= wr_data[1];
                    end
                    ADDR_AD: begin
                        attack <= wr_data[7:4];
                        decay  <= wr_data[3:0];
                    end
                    ADDR_SR: begin
                        sustain <= wr_data[7:4];
                        rel     <= wr_data[3:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_control_regs.sv
// Directed bench for voice_control_regs: stimulus queues hand-computed output
// snapshots tagged with a cycle number; a monitor compares them on the falling edge.
module tb_voice_control_regs;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        bad_addr;
    logic [15:0] tone_freq;
    logic [11:0] pulse_width;
    logic [3:0]  waveform_enable;
    logic        gate;
    logic        en_sync;
    logic        en_ringmod;
    logic [3:0]  attack;
    logic [3:0]  decay;
    logic [3:0]  sustain;
    logic [3:0]  rel;

    voice_control_regs #(.RETRIG_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .bad_addr(bad_addr),
        .tone_freq(tone_freq),
        .pulse_width(pulse_width),
        .waveform_enable(waveform_enable),
        .gate(gate),
        .en_sync(en_sync),
        .en_ringmod(en_ringmod),
        .attack(attack),
        .decay(decay),
        .sustain(sustain),
        .rel(rel)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] tf;
        logic [11:0] pw;
        logic [3:0]  we;
        logic        g;
        logic        es;
        logic        er;
        logic [3:0]  a;
        logic [3:0]  d;
        logic [3:0]  s;
        logic [3:0]  r;
        logic        ba;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [52:0] pack_exp(exp_t e);
        return {e.tf, e.pw, e.we, e.g, e.es, e.er, e.a, e.d, e.s, e.r, e.ba, e.rdy};
    endfunction

    function automatic logic [52:0] pack_dut();
        return {tone_freq, pulse_width, waveform_enable, gate, en_sync, en_ringmod,
                attack, decay, sustain, rel, bad_addr, wr_ready};
    endfunction

    // Monitor: compare every snapshot due this cycle against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (pack_dut() !== pack_exp(e)) begin
                failures++;
                $display("FAIL %s: got tf=%h pw=%h we=%h g=%b es=%b er=%b a=%h d=%h s=%h r=%h ba=%b rdy=%b, want tf=%h pw=%h we=%h g=%b es=%b er=%b a=%h d=%h s=%h r=%h ba=%b rdy=%b",
                         e.name, tone_freq, pulse_width, waveform_enable, gate, en_sync,
                         en_ringmod, attack, decay, sustain, rel, bad_addr, wr_ready,
                         e.tf, e.pw, e.we, e.g, e.es, e.er, e.a, e.d, e.s, e.r, e.ba, e.rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string n);
        exp_t e;
        e = cur;
        e.cyc = cyc;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic clear_cur();
        cur = '{cyc: 0, name: "", tf: 16'h0, pw: 12'h0, we: 4'h0, g: 1'b0, es: 1'b0,
                er: 1'b0, a: 4'h0, d: 4'h0, s: 4'h0, r: 4'h0, ba: 1'b0, rdy: 1'b1};
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #200000;
        if (!done) begin
            failures++;
            $display("FAIL timeout: run did not complete, pending=%0d", q.size());
            finish_run();
        end
    end

    initial begin
        clear_cur();
        rst = 1'b0;
        wr_valid = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h00;
        repeat (3) tick();
        expect_now("reset_state");
        tick();
        rst = 1'b1;
        tick();
        expect_now("post_reset_idle");

        wr(3'd0, 8'h34);
        expect_now("freq_lo_shadow_only");
        wr(3'd1, 8'h12);
        cur.tf = 16'h1234;
        expect_now("freq_commit");

        wr(3'd2, 8'hFF);
        expect_now("pw_lo_shadow_only");
        wr(3'd3, 8'hA7);
        cur.pw = 12'h7FF;
        expect_now("pw_commit");
        wr(3'd3, 8'h01);
        cur.pw = 12'h1FF;
        expect_now("pw_reuse_shadow");
        wr(3'd1, 8'hAB);
        cur.tf = 16'hAB34;
        expect_now("freq_reuse_shadow");

        wr(3'd4, 8'h41);
        cur.we = 4'h4; cur.g = 1'b1;
        expect_now("ctrl_gate_on");
        wr(3'd4, 8'h49);
        cur.g = 1'b0; cur.rdy = 1'b0;
        expect_now("retrig_low_1");
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_now($sformatf("retrig_low_%0d", i));
        end
        tick();
        cur.g = 1'b1; cur.rdy = 1'b1;
        expect_now("retrig_release");

        // Hold a write across a second retrigger; it must land only once ready returns.
        wr(3'd4, 8'h49);
        cur.g = 1'b0; cur.rdy = 1'b0;
        expect_now("held_retrig_1");
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'h9C;
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_now($sformatf("held_retrig_%0d", i));
        end
        tick();
        cur.g = 1'b1; cur.rdy = 1'b1;
        expect_now("held_not_yet_taken");
        tick();
        wr_valid = 1'b0;
        cur.a = 4'h9; cur.d = 4'hC;
        expect_now("held_write_accepted");

        wr(3'd6, 8'h53);
        cur.s = 4'h5; cur.r = 4'h3;
        expect_now("env_sr");
        wr(3'd7, 8'hFF);
        cur.ba = 1'b1;
        expect_now("bad_addr_pulse");
        tick();
        cur.ba = 1'b0;
        expect_now("bad_addr_clear");

        wr(3'd4, 8'h08);
        cur.we = 4'h0; cur.g = 1'b0;
        expect_now("retrig_no_request");
        wr(3'd4, 8'h09);
        cur.g = 1'b1;
        expect_now("retrig_gate_was_low");
        wr(3'd4, 8'hF7);
        cur.we = 4'hF; cur.es = 1'b1; cur.er = 1'b1;
        expect_now("ctrl_all_enables");

        wr(3'd4, 8'hF9);
        cur.es = 1'b0; cur.er = 1'b0; cur.g = 1'b0; cur.rdy = 1'b0;
        expect_now("retrig_abort_start");
        tick();
        rst = 1'b0;
        clear_cur();
        expect_now("async_reset_mid_retrig");
        tick();
        rst = 1'b1;
        tick();
        expect_now("gate_low_after_release");
        repeat (4) tick();
        expect_now("gate_still_low");
        wr(3'd4, 8'h01);
        cur.g = 1'b1;
        expect_now("gate_after_new_ctrl");
        wr(3'd1, 8'h56);
        cur.tf = 16'h5600;
        expect_now("shadow_cleared_by_reset");

        repeat (3) tick();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
        end
        done = 1;
        finish_run();
    end

endmodule
